// File: rtl/lfsr3_monitor_if.sv
// ---------------------------------------------------------------------------
// lfsr3_monitor_if
//   Bundles the stream and status signals of the 3-bit LFSR monitor.
//   master : stimulus side (drives EN/DIN/CLR, observes status)
//   slave  : monitor side  (observes EN/DIN/CLR, drives status)
// Signals
//   EN       generator enable, sampled on the shared clock edge
//   DIN[2:0] generator OUT value
//   CLR      synchronous clear of counters/flags
//   LOCKED   monitor is locked onto the sequence
//   ERR      one-cycle pulse per detected mismatch or zero state
//   STUCK    sticky all-zero lock-up flag
//   ERR_CNT  saturating count of locked mismatches
//   PERIOD   last measured SEED-to-SEED step count
//   PER_VLD  sticky: PERIOD holds a valid measurement
// ---------------------------------------------------------------------------
interface lfsr3_monitor_if #(
  parameter int ERR_W = 8
);
  logic             EN;
  logic [2:0]       DIN;
  logic             CLR;
  logic             LOCKED;
  logic             ERR;
  logic             STUCK;
  logic [ERR_W-1:0] ERR_CNT;
  logic [3:0]       PERIOD;
  logic             PER_VLD;

  modport master (
    output EN, DIN, CLR,
    input  LOCKED, ERR, STUCK, ERR_CNT, PERIOD, PER_VLD
  );

  modport slave (
    input  EN, DIN, CLR,
    output LOCKED, ERR, STUCK, ERR_CNT, PERIOD, PER_VLD
  );
endinterface

// File: rtl/lfsr3_monitor.sv
// ---------------------------------------------------------------------------
// lfsr3_monitor
//   On-line checker for a 3-bit LFSR generator, next(x) = {x[2]^x[0], x[2], x[1]}.
//   Predicts every sample from the previous one, tracks lock, counts locked
//   mismatches, measures the SEED-to-SEED period and flags the all-zero state.
// Ports
//   CLK   in  clock, rising edge, shared with the generator
//   RSTN  in  asynchronous active-low reset
//   mon   slave side of lfsr3_monitor_if (EN/DIN/CLR in, status out)
// Parameters
//   LOCK_N  good advancing steps needed to lock (1..15)
//   ERR_W   width of the saturating error counter
//   SEED    generator reset value, marks the period start
// ---------------------------------------------------------------------------
module lfsr3_monitor #(
  parameter int         LOCK_N = 4,
  parameter int         ERR_W  = 8,
  parameter logic [2:0] SEED   = 3'b100
) (
  input  logic                CLK,
  input  logic                RSTN,
  lfsr3_monitor_if.slave      mon
);

  typedef enum logic [1:0] {IDLE, SYNC, LOCK, STK} state_t;

  localparam logic [3:0] LOCK_N4 = 4'(LOCK_N);

  state_t           state, state_nxt;
  logic [2:0]       prev;
  logic             en_q;
  logic             prev_vld;
  logic [3:0]       cnt, cnt_nxt;
  logic [3:0]       per_cnt, per_cnt_nxt;
  logic             armed, armed_nxt;
  logic [ERR_W-1:0] err_cnt, err_cnt_nxt;
  logic             err, err_nxt;
  logic [3:0]       period, period_nxt;
  logic             per_vld, per_vld_nxt;

  logic [2:0]       exp_v;
  logic [3:0]       cnt_inc;
  logic             mismatch;
  logic             zero;
  logic             adv;

  function automatic logic [2:0] lfsr_next(input logic [2:0] x);
    return {x[2] ^ x[0], x[2], x[1]};
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The generator updates on the same edge that samples EN, so the value seen
  // now reflects the enable captured one edge earlier.
  assign exp_v    = en_q ? lfsr_next(prev) : prev;
  assign mismatch = prev_vld && (mon.DIN != exp_v);
  assign zero     = (mon.DIN == 3'b000);
  assign adv      = en_q && !mismatch;
  assign cnt_inc  = cnt + 4'd1;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    per_cnt_nxt = per_cnt;
    armed_nxt   = armed;
    err_cnt_nxt = err_cnt;
    err_nxt     = 1'b0;
    period_nxt  = period;
    per_vld_nxt = per_vld;

    if (mon.CLR) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      per_cnt_nxt = '0;
      armed_nxt   = 1'b0;
      err_cnt_nxt = '0;
      period_nxt  = '0;
      per_vld_nxt = 1'b0;
    end else if (state != STK && zero) begin
      // Zero wins over a simultaneous mismatch: a single ERR pulse.
      state_nxt   = STK;
      err_nxt     = 1'b1;
      cnt_nxt     = '0;
      per_cnt_nxt = '0;
      armed_nxt   = 1'b0;
      if (state == LOCK) err_cnt_nxt = sat_inc_err(err_cnt);
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SYNC;
          cnt_nxt   = '0;
        end
        SYNC: begin
          if (mismatch) begin
            cnt_nxt = '0;
          end else if (adv) begin
            if (cnt_inc >= LOCK_N4) begin
              state_nxt   = LOCK;
              cnt_nxt     = '0;
              per_cnt_nxt = '0;
              armed_nxt   = 1'b0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end
        end
        LOCK: begin
          if (mismatch) begin
            state_nxt   = SYNC;
            err_nxt     = 1'b1;
            err_cnt_nxt = sat_inc_err(err_cnt);
            cnt_nxt     = '0;
            per_cnt_nxt = '0;
            armed_nxt   = 1'b0;
          end else if (adv) begin
            if (mon.DIN == SEED) begin
              // First SEED after locking only arms the measurement.
              if (armed) begin
                period_nxt  = sat_inc4(per_cnt);
                per_vld_nxt = 1'b1;
              end
              armed_nxt   = 1'b1;
              per_cnt_nxt = '0;
            end else begin
              per_cnt_nxt = sat_inc4(per_cnt);
            end
          end
        end
        STK: begin
          state_nxt = STK;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      prev     <= '0;
      en_q     <= 1'b0;
      prev_vld <= 1'b0;
      cnt      <= '0;
      per_cnt  <= '0;
      armed    <= 1'b0;
      err_cnt  <= '0;
      err      <= 1'b0;
      period   <= '0;
      per_vld  <= 1'b0;
    end else begin
      state    <= state_nxt;
      prev     <= mon.DIN;
      en_q     <= mon.EN;
      prev_vld <= 1'b1;
      cnt      <= cnt_nxt;
      per_cnt  <= per_cnt_nxt;
      armed    <= armed_nxt;
      err_cnt  <= err_cnt_nxt;
      err      <= err_nxt;
      period   <= period_nxt;
      per_vld  <= per_vld_nxt;
    end
  end

  assign mon.LOCKED  = (state == LOCK);
  assign mon.STUCK   = (state == STK);
  assign mon.ERR     = err;
  assign mon.ERR_CNT = err_cnt;
  assign mon.PERIOD  = period;
  assign mon.PER_VLD = per_vld;

endmodule

// File: tb/tb_lfsr3_monitor.sv
// ---------------------------------------------------------------------------
// tb_lfsr3_monitor
//   Drives two monitors (ERR_W=8 and ERR_W=2) from one generator-like stream.
//   A behavioural model tracks lock/stuck/period with plain integers and is
//   compared after every clock; a hand-filled table covers the start-up run and
//   short directed sequences cover hold, mismatch, saturation, zero, CLR and
//   asynchronous reset.
// ---------------------------------------------------------------------------
module tb_lfsr3_monitor;
  localparam int         LOCK_N = 4;
  localparam logic [2:0] SEED   = 3'b100;

  logic       CLK  = 1'b0;
  logic       RSTN = 1'b0;
  logic       en   = 1'b0;
  logic [2:0] din  = 3'b000;
  logic       clr  = 1'b0;

  always #5 CLK = ~CLK;

  lfsr3_monitor_if #(.ERR_W(8)) ifa ();
  lfsr3_monitor_if #(.ERR_W(2)) ifb ();

  assign ifa.EN  = en;
  assign ifa.DIN = din;
  assign ifa.CLR = clr;
  assign ifb.EN  = en;
  assign ifb.DIN = din;
  assign ifb.CLR = clr;

  lfsr3_monitor #(.LOCK_N(LOCK_N), .ERR_W(8), .SEED(SEED)) dut_a (
    .CLK (CLK),
    .RSTN(RSTN),
    .mon (ifa)
  );

  lfsr3_monitor #(.LOCK_N(LOCK_N), .ERR_W(2), .SEED(SEED)) dut_b (
    .CLK (CLK),
    .RSTN(RSTN),
    .mon (ifb)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int gen;

  // Reference model state
  bit m_fresh, m_locked, m_stuck, m_err, m_pvld, m_prev_en, m_have_prev;
  int m_run, m_errs, m_since, m_period, m_prev;

  typedef struct {
    logic       en;
    logic [2:0] din;
    logic       exp_locked;
    logic [3:0] exp_period;
    logic       exp_pvld;
  } vec_t;

  vec_t tbl [16];

  function automatic int nxt(int x);
    return x / 2 + 4 * (((x / 4) + x) % 2);
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(string name, int act, int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_fresh = 1; m_locked = 0; m_stuck = 0; m_err = 0; m_pvld = 0;
    m_prev_en = 0; m_have_prev = 0; m_run = 0; m_errs = 0;
    m_since = -1; m_period = 0; m_prev = 0;
  endtask

  task automatic model_step(bit e, int d, bit c);
    int  want;
    bit  bad, good, zero;
    want = m_prev_en ? nxt(m_prev) : m_prev;
    bad  = m_have_prev && (d != want);
    good = m_prev_en && !bad;
    zero = (d == 0);
    m_err = 0;
    if (c) begin
      m_fresh = 1; m_locked = 0; m_stuck = 0; m_run = 0; m_since = -1;
      m_errs = 0; m_period = 0; m_pvld = 0;
    end else if (m_stuck) begin
      m_stuck = 1;
    end else if (zero) begin
      m_err = 1;
      if (m_locked) m_errs++;
      m_stuck = 1; m_locked = 0; m_fresh = 0; m_run = 0; m_since = -1;
    end else if (m_fresh) begin
      m_fresh = 0;
    end else if (!m_locked) begin
      if (bad) m_run = 0;
      else if (good) begin
        m_run++;
        if (m_run >= LOCK_N) begin
          m_locked = 1; m_run = 0; m_since = -1;
        end
      end
    end else begin
      if (bad) begin
        m_err = 1; m_errs++; m_locked = 0; m_run = 0; m_since = -1;
      end else if (good) begin
        if (d == int'(SEED)) begin
          if (m_since >= 0) begin
            m_period = imin(m_since + 1, 15);
            m_pvld   = 1;
          end
          m_since = 0;
        end else if (m_since >= 0) begin
          m_since = imin(m_since + 1, 15);
        end
      end
    end
    m_prev = d; m_prev_en = e; m_have_prev = 1;
  endtask

  task automatic compare_model();
    check("locked",  ifa.LOCKED,  m_locked);
    check("err",     ifa.ERR,     m_err);
    check("stuck",   ifa.STUCK,   m_stuck);
    check("errcnt8", ifa.ERR_CNT, imin(m_errs, 255));
    check("errcnt2", ifb.ERR_CNT, imin(m_errs, 3));
    check("period",  ifa.PERIOD,  m_period);
    check("pervld",  ifa.PER_VLD, m_pvld);
  endtask

  // Inputs are set at the falling edge before calling; the model steps on the
  // rising edge and the DUT is compared on the following falling edge.
  task automatic tick();
    @(posedge CLK);
    model_step(en, int'(din), clr);
    if (en) gen = nxt(gen);
    @(negedge CLK);
    compare_model();
  endtask

  task automatic step_gen(bit e);
    en  = e;
    din = 3'(gen);
    tick();
  endtask

  task automatic wait_lock(string nm);
    int k;
    k = 0;
    while (!ifa.LOCKED && k < 20) begin
      step_gen(1'b1);
      k++;
    end
    check(nm, ifa.LOCKED, 1);
  endtask

  task automatic run_until_gen(int v, string nm);
    int k;
    k = 0;
    while (gen != v && k < 10) begin
      step_gen(1'b1);
      k++;
    end
    check(nm, gen, v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] g;
    tbl[0]  = '{1'b1, 3'b100, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{1'b1, 3'b110, 1'b0, 4'd0, 1'b0};
    tbl[2]  = '{1'b1, 3'b111, 1'b0, 4'd0, 1'b0};
    tbl[3]  = '{1'b1, 3'b011, 1'b0, 4'd0, 1'b0};
    tbl[4]  = '{1'b1, 3'b101, 1'b1, 4'd0, 1'b0};
    tbl[5]  = '{1'b1, 3'b010, 1'b1, 4'd0, 1'b0};
    tbl[6]  = '{1'b1, 3'b001, 1'b1, 4'd0, 1'b0};
    tbl[7]  = '{1'b1, 3'b100, 1'b1, 4'd0, 1'b0};
    tbl[8]  = '{1'b1, 3'b110, 1'b1, 4'd0, 1'b0};
    tbl[9]  = '{1'b1, 3'b111, 1'b1, 4'd0, 1'b0};
    tbl[10] = '{1'b1, 3'b011, 1'b1, 4'd0, 1'b0};
    tbl[11] = '{1'b1, 3'b101, 1'b1, 4'd0, 1'b0};
    tbl[12] = '{1'b1, 3'b010, 1'b1, 4'd0, 1'b0};
    tbl[13] = '{1'b1, 3'b001, 1'b1, 4'd0, 1'b0};
    tbl[14] = '{1'b1, 3'b100, 1'b1, 4'd7, 1'b1};
    tbl[15] = '{1'b1, 3'b110, 1'b1, 4'd7, 1'b1};

    model_reset();
    gen  = int'(SEED);
    RSTN = 1'b0;
    en   = 1'b0;
    din  = SEED;
    clr  = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_locked", ifa.LOCKED,  0);
    check("rst_err",    ifa.ERR,     0);
    check("rst_stuck",  ifa.STUCK,   0);
    check("rst_errcnt", ifa.ERR_CNT, 0);
    check("rst_period", ifa.PERIOD,  0);
    check("rst_pervld", ifa.PER_VLD, 0);
    RSTN = 1'b1;

    // Start-up run from reset: lock after LOCK_N+1 edges, period 7 after 2nd SEED
    for (int i = 0; i < 16; i++) begin
      en  = tbl[i].en;
      din = tbl[i].din;
      tick();
      check("t1_locked", ifa.LOCKED,  tbl[i].exp_locked);
      check("t1_period", ifa.PERIOD,  tbl[i].exp_period);
      check("t1_pervld", ifa.PER_VLD, tbl[i].exp_pvld);
      check("t1_err",    ifa.ERR,     0);
    end

    // Hold EN=0 with DIN at 011 while locked
    run_until_gen(3, "t2_reach011");
    for (int i = 0; i < 5; i++) begin
      step_gen(1'b0);
      check("t2_hold_err",    ifa.ERR,    0);
      check("t2_hold_locked", ifa.LOCKED, 1);
    end
    for (int i = 0; i < 15; i++) step_gen(1'b1);
    check("t2_period", ifa.PERIOD,  7);
    check("t2_pervld", ifa.PER_VLD, 1);
    check("t2_locked", ifa.LOCKED,  1);

    // Wrong value 101 where 111 is expected
    run_until_gen(7, "t3_reach111");
    en  = 1'b1;
    din = 3'b101;
    tick();
    check("t3_err",    ifa.ERR,     1);
    check("t3_errcnt", ifa.ERR_CNT, 1);
    check("t3_locked", ifa.LOCKED,  0);
    step_gen(1'b1);
    check("t3_err_pulse", ifa.ERR, 0);
    wait_lock("t3_relock");

    // Five locked mismatches, relocking in between: narrow counter saturates
    for (int i = 0; i < 5; i++) begin
      g   = 3'(gen);
      en  = 1'b1;
      din = (g == 3'b001) ? (g ^ 3'b010) : (g ^ 3'b001);
      tick();
      check("t5_err", ifa.ERR, 1);
      wait_lock("t5_relock");
    end
    check("t5_errcnt2", ifb.ERR_CNT, 3);
    check("t5_errcnt8", ifa.ERR_CNT, 6);

    // All-zero state, then CLR
    en  = 1'b1;
    din = 3'b000;
    tick();
    check("t4_err",    ifa.ERR,     1);
    check("t4_stuck",  ifa.STUCK,   1);
    check("t4_locked", ifa.LOCKED,  0);
    check("t4_errcnt", ifa.ERR_CNT, 7);
    step_gen(1'b1);
    step_gen(1'b1);
    check("t4_err_once",    ifa.ERR,   0);
    check("t4_stuck_stays", ifa.STUCK, 1);
    clr = 1'b1;
    step_gen(1'b1);
    clr = 1'b0;
    check("t4_clr_stuck",  ifa.STUCK,   0);
    check("t4_clr_err",    ifa.ERR,     0);
    check("t4_clr_locked", ifa.LOCKED,  0);
    check("t4_clr_errcnt", ifa.ERR_CNT, 0);
    check("t4_clr_period", ifa.PERIOD,  0);
    check("t4_clr_pervld", ifa.PER_VLD, 0);
    wait_lock("t4_relock");
    for (int i = 0; i < 16; i++) step_gen(1'b1);

    // Asynchronous reset between edges
    #2;
    RSTN = 1'b0;
    #1;
    check("t6_locked", ifa.LOCKED,  0);
    check("t6_period", ifa.PERIOD,  0);
    check("t6_pervld", ifa.PER_VLD, 0);
    check("t6_errcnt", ifb.ERR_CNT, 0);
    model_reset();
    gen = int'(SEED);
    en  = 1'b1;
    din = SEED;
    @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    for (int k = 1; k <= LOCK_N + 1; k++) begin
      step_gen(1'b1);
      if (k == LOCK_N)     check("t6_not_yet", ifa.LOCKED, 0);
      if (k == LOCK_N + 1) check("t6_relock",  ifa.LOCKED, 1);
      check("t6_no_err", ifa.ERR, 0);
    end

    // Randomized stream against the model
    for (int i = 0; i < 1000; i++) begin
      int r;
      r   = int'($urandom_range(0, 99));
      en  = ($urandom_range(0, 9) != 0);
      clr = 1'b0;
      din = 3'(gen);
      if (m_stuck)     clr = ($urandom_range(0, 3) == 0);
      else if (r < 2)  din = 3'b000;
      else if (r < 7)  din = 3'($urandom_range(1, 7));
      else if (r < 9)  clr = 1'b1;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
